// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: axis state encoding and
// standard CEA-861 timing sets for 1080p60 and 720p60.
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } vtg_state_e;

    localparam int VTG_1080P60_H_ACTIVE = 1920;
    localparam int VTG_1080P60_H_FRONT  = 88;
    localparam int VTG_1080P60_H_SYNC   = 44;
    localparam int VTG_1080P60_H_BACK   = 148;
    localparam int VTG_1080P60_V_ACTIVE = 1080;
    localparam int VTG_1080P60_V_FRONT  = 4;
    localparam int VTG_1080P60_V_SYNC   = 5;
    localparam int VTG_1080P60_V_BACK   = 36;

    localparam int VTG_720P60_H_ACTIVE  = 1280;
    localparam int VTG_720P60_H_FRONT   = 110;
    localparam int VTG_720P60_H_SYNC    = 40;
    localparam int VTG_720P60_H_BACK    = 220;
    localparam int VTG_720P60_V_ACTIVE  = 720;
    localparam int VTG_720P60_V_FRONT   = 5;
    localparam int VTG_720P60_V_SYNC    = 5;
    localparam int VTG_720P60_V_BACK    = 20;

    function automatic vtg_state_e vtg_next_state(input vtg_state_e cur);
        vtg_state_e nxt;
        case (cur)
            ST_SYNC:   nxt = ST_BACK;
            ST_BACK:   nxt = ST_ACTIVE;
            ST_ACTIVE: nxt = ST_FRONT;
            ST_FRONT:  nxt = ST_SYNC;
            default:   nxt = ST_SYNC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle of the generator's video outputs; master drives, slave consumes.
interface video_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;

    modport master (output de, hsync, vsync, line_start, frame_start, pixel_x, pixel_y);
    modport slave  (input  de, hsync, vsync, line_start, frame_start, pixel_x, pixel_y);
endinterface

// File: rtl/vtg_axis_counter.sv
// One timing axis: position counter plus SYNC/BACK/ACTIVE/FRONT region FSM.
// wrap is high in the cycle the counter steps from its last position back to 0.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int LEN_SYNC   = 1,
    parameter int LEN_BACK   = 1,
    parameter int LEN_ACTIVE = 1,
    parameter int LEN_FRONT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output vtg_state_e       state,
    output logic             wrap
);

    localparam int TOTAL = LEN_SYNC + LEN_BACK + LEN_ACTIVE + LEN_FRONT;
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(LEN_SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BACK   = CNT_W'(LEN_SYNC + LEN_BACK - 1);
    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(LEN_SYNC + LEN_BACK + LEN_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_d, count_q;
    vtg_state_e       state_d, state_q;
    logic             region_end_s;

    // Next position and region; a region ends on its last count, so a length of 1 is one step.
    always_comb begin
        count_d      = count_q;
        state_d      = state_q;
        region_end_s = 1'b0;
        case (state_q)
            ST_SYNC:   region_end_s = (count_q == LAST_SYNC);
            ST_BACK:   region_end_s = (count_q == LAST_BACK);
            ST_ACTIVE: region_end_s = (count_q == LAST_ACTIVE);
            ST_FRONT:  region_end_s = (count_q == LAST_COUNT);
            default:   region_end_s = 1'b1;
        endcase
        if (advance) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            if (region_end_s) begin
                state_d = vtg_next_state(state_q);
            end else begin
                state_d = state_q;
            end
        end else begin
            count_d = count_q;
            state_d = state_q;
        end
    end

    // Position and region registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            state_q <= ST_SYNC;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign wrap  = advance && (count_q == LAST_COUNT);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered DE/HSYNC/VSYNC, line/frame pulses and coordinates.
// Define VIDEO_TIMING_GEN_COORD_EN to build the pixelX/pixelY registers; otherwise they read 0.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VTG_1080P60_H_ACTIVE,
    parameter int H_FRONT  = VTG_1080P60_H_FRONT,
    parameter int H_SYNC   = VTG_1080P60_H_SYNC,
    parameter int H_BACK   = VTG_1080P60_H_BACK,
    parameter int V_ACTIVE = VTG_1080P60_V_ACTIVE,
    parameter int V_FRONT  = VTG_1080P60_V_FRONT,
    parameter int V_SYNC   = VTG_1080P60_V_SYNC,
    parameter int V_BACK   = VTG_1080P60_V_BACK,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int CNT_W    = 12
) (
    input  logic             pixelClock,
    input  logic             resetN,
    input  logic             enable,
    output logic             DE,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             lineStart,
    output logic             frameStart,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY
);

    localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    if ((HT > (1 << CNT_W)) || (VT > (1 << CNT_W))) begin : g_size_check
        $error("video_timing_gen: HT or VT does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] h_count_s, v_count_s;
    vtg_state_e       h_state_s, v_state_s;
    logic             h_wrap_s, v_wrap_s;

    vtg_axis_counter #(
        .CNT_W(CNT_W), .LEN_SYNC(H_SYNC), .LEN_BACK(H_BACK),
        .LEN_ACTIVE(H_ACTIVE), .LEN_FRONT(H_FRONT)
    ) u_h_axis (
        .clk(pixelClock), .rst_n(resetN), .advance(enable),
        .count(h_count_s), .state(h_state_s), .wrap(h_wrap_s)
    );

    vtg_axis_counter #(
        .CNT_W(CNT_W), .LEN_SYNC(V_SYNC), .LEN_BACK(V_BACK),
        .LEN_ACTIVE(V_ACTIVE), .LEN_FRONT(V_FRONT)
    ) u_v_axis (
        .clk(pixelClock), .rst_n(resetN), .advance(h_wrap_s),
        .count(v_count_s), .state(v_state_s), .wrap(v_wrap_s)
    );

    logic de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q;
    logic line_start_d, line_start_q, frame_start_d, frame_start_q;
    logic frame_origin_d, frame_origin_q;

    // Decode the current position into next-cycle outputs; frozen (pulses cleared) while disabled.
    // frame_origin tracks "position is (0,0)": set by the edge on which both axes wrap.
    always_comb begin
        de_d           = de_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        frame_origin_d = frame_origin_q;
        if (enable) begin
            hsync_d        = (h_count_s < CNT_W'(H_SYNC)) ? H_POL : ~H_POL;
            vsync_d        = (v_count_s < CNT_W'(V_SYNC)) ? V_POL : ~V_POL;
            de_d           = (h_state_s == ST_ACTIVE) && (v_state_s == ST_ACTIVE);
            line_start_d   = (h_count_s == '0);
            frame_start_d  = frame_origin_q;
            frame_origin_d = v_wrap_s;
        end else begin
            frame_origin_d = frame_origin_q;
        end
    end

    // Output registers.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            de_q           <= 1'b0;
            hsync_q        <= ~H_POL;
            vsync_q        <= ~V_POL;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_origin_q <= 1'b1;
        end else begin
            de_q           <= de_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            frame_origin_q <= frame_origin_d;
        end
    end

    assign DE         = de_q;
    assign HSYNC      = hsync_q;
    assign VSYNC      = vsync_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;

`ifdef VIDEO_TIMING_GEN_COORD_EN
    logic [CNT_W-1:0] pixel_x_d, pixel_x_q, pixel_y_d, pixel_y_q;

    // Coordinates follow the position inside the active window and hold outside it.
    always_comb begin
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (enable && (h_state_s == ST_ACTIVE) && (v_state_s == ST_ACTIVE)) begin
            pixel_x_d = h_count_s - CNT_W'(H_SYNC + H_BACK);
            pixel_y_d = v_count_s - CNT_W'(V_SYNC + V_BACK);
        end else begin
            pixel_x_d = pixel_x_q;
            pixel_y_d = pixel_y_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            pixel_x_q <= '0;
            pixel_y_q <= '0;
        end else begin
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
        end
    end

    assign pixelX = pixel_x_q;
    assign pixelY = pixel_y_q;
`else
    assign pixelX = '0;
    assign pixelY = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Three generators (1080p defaults, tiny 8x6 raster, tiny active-low raster) checked
// every cycle against a raster model, plus measured sync/DE widths and periods.
module tb_video_timing_gen;

    localparam int N = 3;
`ifdef VIDEO_TIMING_GEN_COORD_EN
    localparam bit COORD_EN = 1'b1;
`else
    localparam bit COORD_EN = 1'b0;
`endif

    localparam int HS_C [N] = '{44, 2, 3};
    localparam int HB_C [N] = '{148, 1, 1};
    localparam int HA_C [N] = '{1920, 4, 5};
    localparam int HF_C [N] = '{88, 1, 1};
    localparam int VS_C [N] = '{5, 1, 2};
    localparam int VB_C [N] = '{36, 1, 1};
    localparam int VA_C [N] = '{1080, 3, 2};
    localparam int VF_C [N] = '{4, 1, 2};
    localparam int HP_C [N] = '{1, 1, 0};
    localparam int VP_C [N] = '{1, 1, 0};

    logic clk = 1'b0;
    logic resetN;
    logic enable;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CNT_W(12)) vif0 ();
    video_timing_gen_if #(.CNT_W(3))  vif1 ();
    video_timing_gen_if #(.CNT_W(4))  vif2 ();

    video_timing_gen dut0 (
        .pixelClock(clk), .resetN(resetN), .enable(enable),
        .DE(vif0.de), .HSYNC(vif0.hsync), .VSYNC(vif0.vsync),
        .lineStart(vif0.line_start), .frameStart(vif0.frame_start),
        .pixelX(vif0.pixel_x), .pixelY(vif0.pixel_y)
    );

    video_timing_gen #(
        .H_ACTIVE(HA_C[1]), .H_FRONT(HF_C[1]), .H_SYNC(HS_C[1]), .H_BACK(HB_C[1]),
        .V_ACTIVE(VA_C[1]), .V_FRONT(VF_C[1]), .V_SYNC(VS_C[1]), .V_BACK(VB_C[1]),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(3)
    ) dut1 (
        .pixelClock(clk), .resetN(resetN), .enable(enable),
        .DE(vif1.de), .HSYNC(vif1.hsync), .VSYNC(vif1.vsync),
        .lineStart(vif1.line_start), .frameStart(vif1.frame_start),
        .pixelX(vif1.pixel_x), .pixelY(vif1.pixel_y)
    );

    video_timing_gen #(
        .H_ACTIVE(HA_C[2]), .H_FRONT(HF_C[2]), .H_SYNC(HS_C[2]), .H_BACK(HB_C[2]),
        .V_ACTIVE(VA_C[2]), .V_FRONT(VF_C[2]), .V_SYNC(VS_C[2]), .V_BACK(VB_C[2]),
        .H_POL(1'b0), .V_POL(1'b0), .CNT_W(4)
    ) dut2 (
        .pixelClock(clk), .resetN(resetN), .enable(enable),
        .DE(vif2.de), .HSYNC(vif2.hsync), .VSYNC(vif2.vsync),
        .lineStart(vif2.line_start), .frameStart(vif2.frame_start),
        .pixelX(vif2.pixel_x), .pixelY(vif2.pixel_y)
    );

    int checks = 0;
    int failures = 0;

    // Raster model: current position and expected registered outputs.
    int hpos [N];
    int vpos [N];
    int e_de [N], e_hs [N], e_vs [N], e_ls [N], e_fs [N], e_px [N], e_py [N];
    logic [31:0] o_de [N], o_hs [N], o_vs [N], o_ls [N], o_fs [N], o_px [N], o_py [N];

    // Measurement trackers, counted in enabled clocks.
    int en_cnt;
    int hs_rise0, de_rise0, fs_last1, de_fall1;
    logic [31:0] p_hs0, p_de0, p_hs1, p_de1;
    bit de_seen1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hpos[i] = 0; vpos[i] = 0;
            e_de[i] = 0; e_ls[i] = 0; e_fs[i] = 0; e_px[i] = 0; e_py[i] = 0;
            e_hs[i] = 1 - HP_C[i];
            e_vs[i] = 1 - VP_C[i];
        end
    endtask

    task automatic model_edge(input bit en);
        int hx, vy;
        for (int i = 0; i < N; i++) begin
            if (en) begin
                hx = hpos[i] - (HS_C[i] + HB_C[i]);
                vy = vpos[i] - (VS_C[i] + VB_C[i]);
                e_hs[i] = (hpos[i] < HS_C[i]) ? HP_C[i] : 1 - HP_C[i];
                e_vs[i] = (vpos[i] < VS_C[i]) ? VP_C[i] : 1 - VP_C[i];
                e_de[i] = (hx >= 0 && hx < HA_C[i] && vy >= 0 && vy < VA_C[i]) ? 1 : 0;
                if (e_de[i] == 1 && COORD_EN) begin
                    e_px[i] = hx;
                    e_py[i] = vy;
                end
                e_ls[i] = (hpos[i] == 0) ? 1 : 0;
                e_fs[i] = (hpos[i] == 0 && vpos[i] == 0) ? 1 : 0;
                hpos[i] = hpos[i] + 1;
                if (hpos[i] == HS_C[i] + HB_C[i] + HA_C[i] + HF_C[i]) begin
                    hpos[i] = 0;
                    vpos[i] = (vpos[i] + 1) % (VS_C[i] + VB_C[i] + VA_C[i] + VF_C[i]);
                end
            end else begin
                e_ls[i] = 0;
                e_fs[i] = 0;
            end
        end
    endtask

    task automatic sample_obs();
        o_de[0] = 32'(vif0.de); o_hs[0] = 32'(vif0.hsync); o_vs[0] = 32'(vif0.vsync);
        o_ls[0] = 32'(vif0.line_start); o_fs[0] = 32'(vif0.frame_start);
        o_px[0] = 32'(vif0.pixel_x); o_py[0] = 32'(vif0.pixel_y);
        o_de[1] = 32'(vif1.de); o_hs[1] = 32'(vif1.hsync); o_vs[1] = 32'(vif1.vsync);
        o_ls[1] = 32'(vif1.line_start); o_fs[1] = 32'(vif1.frame_start);
        o_px[1] = 32'(vif1.pixel_x); o_py[1] = 32'(vif1.pixel_y);
        o_de[2] = 32'(vif2.de); o_hs[2] = 32'(vif2.hsync); o_vs[2] = 32'(vif2.vsync);
        o_ls[2] = 32'(vif2.line_start); o_fs[2] = 32'(vif2.frame_start);
        o_px[2] = 32'(vif2.pixel_x); o_py[2] = 32'(vif2.pixel_y);
    endtask

    task automatic compare_all();
        sample_obs();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("i%0d_de", i),          o_de[i], 32'(e_de[i]));
            chk($sformatf("i%0d_hsync", i),       o_hs[i], 32'(e_hs[i]));
            chk($sformatf("i%0d_vsync", i),       o_vs[i], 32'(e_vs[i]));
            chk($sformatf("i%0d_lineStart", i),   o_ls[i], 32'(e_ls[i]));
            chk($sformatf("i%0d_frameStart", i),  o_fs[i], 32'(e_fs[i]));
            chk($sformatf("i%0d_pixelX", i),      o_px[i], 32'(e_px[i]));
            chk($sformatf("i%0d_pixelY", i),      o_py[i], 32'(e_py[i]));
        end
    endtask

    task automatic tracker_reset();
        en_cnt = 0;
        hs_rise0 = -1; de_rise0 = -1; fs_last1 = -1; de_fall1 = -1;
        p_hs0 = 32'd0; p_de0 = 32'd0; p_hs1 = 32'd0; p_de1 = 32'd0;
        de_seen1 = 1'b0;
    endtask

    task automatic measure();
        en_cnt++;
        if (o_hs[0] == 32'd1 && p_hs0 == 32'd0) begin
            if (hs_rise0 >= 0) chk("i0_hsync_period", 32'(en_cnt - hs_rise0), 32'd2200);
            hs_rise0 = en_cnt;
        end
        if (o_hs[0] == 32'd0 && p_hs0 == 32'd1 && hs_rise0 >= 0)
            chk("i0_hsync_width", 32'(en_cnt - hs_rise0), 32'd44);
        if (o_de[0] == 32'd1 && p_de0 == 32'd0) begin
            if (hs_rise0 >= 0) chk("i0_hsync_to_de", 32'(en_cnt - hs_rise0), 32'd192);
            de_rise0 = en_cnt;
        end
        if (o_de[0] == 32'd0 && p_de0 == 32'd1 && de_rise0 >= 0)
            chk("i0_de_width", 32'(en_cnt - de_rise0), 32'd1920);
        if (o_fs[1] == 32'd1) begin
            if (fs_last1 >= 0) chk("i1_frame_period", 32'(en_cnt - fs_last1), 32'd48);
            fs_last1 = en_cnt;
        end
        if (o_de[1] == 32'd1) de_seen1 = 1'b1;
        if (o_de[1] == 32'd0 && p_de1 == 32'd1) de_fall1 = en_cnt;
        if (o_hs[1] == 32'd1 && p_hs1 == 32'd0) begin
            if (de_seen1) chk("i1_defall_to_hsync", 32'(en_cnt - de_fall1), 32'd1);
            de_seen1 = 1'b0;
        end
        p_hs0 = o_hs[0]; p_de0 = o_de[0]; p_hs1 = o_hs[1]; p_de1 = o_de[1];
    endtask

    task automatic step(input bit en);
        enable = en;
        @(posedge clk);
        if (resetN) model_edge(en);
        @(negedge clk);
        compare_all();
        if (resetN && en) measure();
    endtask

    initial begin
        int guard;
        resetN = 1'b0;
        enable = 1'b0;
        model_reset();
        tracker_reset();
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end

        // First enabled edge after release presents (0,0) with both pulses.
        resetN = 1'b1;
        step(1'b1);
        chk("i1_first_frameStart", o_fs[1], 32'd1);

        guard = 0;
        while ((hpos[0] != 100 || vpos[0] != 2) && guard < 6000) begin
            step(1'b1);
            guard++;
        end
        chk("i0_reach_h100", 32'(guard < 6000), 32'd1);

        repeat (10) step(1'b0);
        repeat (2300) step(1'b1);

        repeat (2500) step($urandom_range(0, 3) != 0);

        // Asynchronous reset in the middle of a frame.
        guard = 0;
        while ((vpos[1] != 3 || hpos[1] == 0) && guard < 200) begin
            step(1'b1);
            guard++;
        end
        chk("i1_reach_mid_frame", 32'(guard < 200), 32'd1);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        tracker_reset();
        compare_all();
        repeat (3) step(1'b1);
        resetN = 1'b1;
        step(1'b1);
        chk("i0_frameStart_after_reset", o_fs[0], 32'd1);

        repeat (2000) step($urandom_range(0, 4) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
